// File: rtl/shared_net_arbiter.sv
// -----------------------------------------------------------------------------
// shared_net_arbiter
//   Round-robin arbiter that hands one shared, heavily loaded net to at most one
//   requester at a time. An owner keeps the grant while it keeps requesting, is
//   force-released after MAX_HOLD cycles (MAX_HOLD = 0 means no limit), and every
//   change of owner is separated by GAP_CYCLES dead cycles plus one IDLE
//   arbitration cycle, so two drivers can never overlap on the net.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   en           : 1 = new grants may be issued (current owner is unaffected)
//   req          : per-requester level request
//   gnt          : registered one-hot grant (or zero)
//   gnt_vld      : registered, equals |gnt
//   gnt_id       : registered index of current owner, holds last owner when idle
//   hold_timeout : registered one-cycle pulse on a MAX_HOLD forced release
// -----------------------------------------------------------------------------
module shared_net_arbiter #(
  parameter int N_REQ      = 20,
  parameter int ID_W       = 5,
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  output logic [ID_W-1:0]  gnt_id,
  output logic             hold_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int IW1  = ID_W + 1;
  localparam int RW   = 1 << ID_W;

  logic [1:0]       r_state;
  logic [N_REQ-1:0] r_gnt;
  logic             r_vld;
  logic [ID_W-1:0]  r_id;
  logic             r_to;
  logic [HC_W-1:0]  r_hold;
  logic [3:0]       r_gap;
  logic [ID_W-1:0]  r_rr;

  logic [1:0]       w_state_nxt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic             w_vld_nxt;
  logic [ID_W-1:0]  w_id_nxt;
  logic             w_to_nxt;
  logic [HC_W-1:0]  w_hold_nxt;
  logic [3:0]       w_gap_nxt;
  logic [ID_W-1:0]  w_rr_nxt;

  logic [RW-1:0]    w_req_ext;
  logic [ID_W:0]    w_idx;
  logic             w_found;
  logic [ID_W-1:0]  w_winner;
  logic [N_REQ-1:0] w_onehot;
  logic             w_owner_req;
  logic             w_timeout;

  // Zero-extend req to a power-of-two width so any ID_W-bit index is in range.
  always_comb begin
    w_req_ext             = '0;
    w_req_ext[N_REQ-1:0]  = req;
  end

  // Round-robin search: first set request starting just after the last owner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, r_rr} + IW1'(1) + IW1'(i);
      if (w_idx >= IW1'(N_REQ)) begin
        w_idx = w_idx - IW1'(N_REQ);
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && w_req_ext[w_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[ID_W-1:0];
      end else begin
        w_found  = w_found;
      end
    end
  end

  // One-hot decode of the winning index.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_onehot[i] = (w_winner == ID_W'(i));
    end
  end

  assign w_owner_req = w_req_ext[r_id];
  assign w_timeout   = (MAX_HOLD != 0) && (r_hold == HC_W'(MAX_HOLD));

  // Next-state and next-output computation for the IDLE/GRANT/GAP sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_vld_nxt   = r_vld;
    w_id_nxt    = r_id;
    w_to_nxt    = 1'b0;
    w_hold_nxt  = r_hold;
    w_gap_nxt   = r_gap;
    w_rr_nxt    = r_rr;
    case (r_state)
      S_IDLE: begin
        if (en && w_found) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = w_onehot;
          w_vld_nxt   = 1'b1;
          w_id_nxt    = w_winner;
          w_hold_nxt  = HC_W'(1);
          w_rr_nxt    = w_winner;
        end else begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_vld_nxt   = 1'b0;
        end
      end
      S_GRANT: begin
        // Only the owner's own request line matters while the grant is held.
        if (!w_owner_req) begin
          w_state_nxt = S_GAP;
          w_gnt_nxt   = '0;
          w_vld_nxt   = 1'b0;
          w_gap_nxt   = 4'd1;
        end else if (w_timeout) begin
          w_state_nxt = S_GAP;
          w_gnt_nxt   = '0;
          w_vld_nxt   = 1'b0;
          w_to_nxt    = 1'b1;
          w_gap_nxt   = 4'd1;
        end else if (r_hold != {HC_W{1'b1}}) begin
          w_hold_nxt  = r_hold + HC_W'(1);
        end else begin
          w_hold_nxt  = r_hold;
        end
      end
      S_GAP: begin
        w_gnt_nxt = '0;
        w_vld_nxt = 1'b0;
        if (r_gap >= 4'(GAP_CYCLES)) begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = 4'd0;
        end else begin
          w_gap_nxt   = r_gap + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_vld_nxt   = 1'b0;
        w_hold_nxt  = '0;
        w_gap_nxt   = 4'd0;
      end
    endcase
  end

  // State and output registers; reset makes req[0] the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_vld   <= 1'b0;
      r_id    <= '0;
      r_to    <= 1'b0;
      r_hold  <= '0;
      r_gap   <= 4'd0;
      r_rr    <= ID_W'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_vld   <= w_vld_nxt;
      r_id    <= w_id_nxt;
      r_to    <= w_to_nxt;
      r_hold  <= w_hold_nxt;
      r_gap   <= w_gap_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  assign gnt          = r_gnt;
  assign gnt_vld      = r_vld;
  assign gnt_id       = r_id;
  assign hold_timeout = r_to;

endmodule

// File: tb/tb_shared_net_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_net_arbiter
//   Directed scoreboard bench for shared_net_arbiter (N_REQ=20, MAX_HOLD=16,
//   GAP_CYCLES=1) followed by a random phase with invariant checks.
// -----------------------------------------------------------------------------
module tb_shared_net_arbiter;

  localparam int N   = 20;
  localparam int MH  = 16;
  localparam int GAP = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic [4:0]   gnt_id;
  logic         hold_timeout;

  typedef struct {
    string        tag;
    logic [N-1:0] gnt;
    logic         vld;
    logic [4:0]   id;
    logic         to;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] exp_id;
  int         n_chk  = 0;
  int         n_fail = 0;

  shared_net_arbiter #(.N_REQ(N), .ID_W(5), .MAX_HOLD(MH), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .req          (req),
    .gnt          (gnt),
    .gnt_vld      (gnt_vld),
    .gnt_id       (gnt_id),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pop the oldest expectation and compare all outputs against it.
  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".gnt"},     32'(gnt),          32'(e.gnt));
    chk({e.tag, ".gnt_vld"}, 32'(gnt_vld),      32'(e.vld));
    chk({e.tag, ".gnt_id"},  32'(gnt_id),       32'(e.id));
    chk({e.tag, ".timeout"}, 32'(hold_timeout), 32'(e.to));
  endtask

  function automatic exp_t mk(input string tag, input int own, input logic to);
    exp_t e;
    e.tag = tag;
    e.gnt = '0;
    e.vld = 1'b0;
    e.to  = to;
    if (own >= 0) begin
      e.gnt[own] = 1'b1;
      e.vld      = 1'b1;
      exp_id     = 5'(own);
    end
    e.id = exp_id;
    return e;
  endfunction

  // Push expected outputs for the coming edge, clock once, then compare.
  task automatic step(input string tag, input int own, input logic to);
    sb.push_back(mk(tag, own, to));
    @(posedge clk);
    #2;
    check_out();
  endtask

  task automatic release_seq(input string tag);
    step({tag, "_rel"}, -1, 1'b0);
    step({tag, "_gap"}, -1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_len, zero_len, prev_run;
    bit seen;
    rst_n  = 1'b1;
    en     = 1'b0;
    req    = '0;
    exp_id = 5'd0;
    #1 rst_n = 1'b0;
    #1;
    sb.push_back(mk("reset", -1, 1'b0));
    check_out();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: single requester 0, three grant cycles then one gap
    en = 1'b1; req = 20'h00001;
    step("t1_g1", 0, 1'b0);
    step("t1_g2", 0, 1'b0);
    step("t1_g3", 0, 1'b0);
    req = '0;
    release_seq("t1");

    // 2: everyone requesting, owners 1..3 each time out after MAX_HOLD cycles
    req = 20'hFFFFF;
    for (int k = 1; k <= 3; k++) begin
      for (int c = 0; c < MH; c++) step("t2_hold", k, 1'b0);
      step("t2_timeout", -1, 1'b1);
      step("t2_gap", -1, 1'b0);
    end
    req = '0;
    step("t2_idle", -1, 1'b0);

    // 3: make 4 the last owner, then 2 and 7 together -> 7 first, then 2
    req = 20'h00010;
    step("t3_own4", 4, 1'b0);
    req = '0;
    release_seq("t3a");
    req = 20'h00084;
    step("t3_own7", 7, 1'b0);
    req = 20'h00004;
    release_seq("t3b");
    step("t3_own2", 2, 1'b0);
    req = '0;
    release_seq("t3c");
    req = 20'h80001;
    step("t3_own19", 19, 1'b0);
    req = 20'h00001;
    release_seq("t3d");
    step("t3_wrap0", 0, 1'b0);
    req = '0;
    release_seq("t3e");

    // 4: enable gating; en low does not disturb a live grant
    en = 1'b0; req = 20'h00010;
    step("t4_noen1", -1, 1'b0);
    step("t4_noen2", -1, 1'b0);
    en = 1'b1;
    step("t4_own4", 4, 1'b0);
    en = 1'b0;
    step("t4_keep1", 4, 1'b0);
    step("t4_keep2", 4, 1'b0);
    step("t4_keep3", 4, 1'b0);
    req = '0;
    release_seq("t4");
    req = 20'h00010;
    step("t4_wait", -1, 1'b0);
    req = '0; en = 1'b1;
    step("t4_idle", -1, 1'b0);

    // 5: asynchronous reset while requester 8 owns the net
    req = 20'h00100;
    step("t5_own8a", 8, 1'b0);
    step("t5_own8b", 8, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_id = 5'd0;
    sb.push_back(mk("t5_async_rst", -1, 1'b0));
    check_out();
    req = 20'h00121;
    #1 rst_n = 1'b1;
    step("t5_own0", 0, 1'b0);
    req = '0;
    release_seq("t5");

    // Single requester that times out is re-granted after the gap
    req = 20'h00020;
    for (int c = 0; c < MH; c++) step("t6_hold5", 5, 1'b0);
    step("t6_timeout", -1, 1'b1);
    step("t6_gap", -1, 1'b0);
    step("t6_regrant", 5, 1'b0);
    req = '0;
    release_seq("t6");

    // Random phase with per-cycle invariant checks
    run_len = 0; zero_len = 0; seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom) & N'($urandom);
      en = ($urandom_range(0, 5) != 0);
      @(posedge clk);
      #2;
      chk("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
      chk("rnd_vld", 32'(gnt_vld), 32'(|gnt));
      prev_run = run_len;
      if (gnt_vld) begin
        chk("rnd_id_range", 32'(gnt_id < 5'd20), 32'd1);
        chk("rnd_id_match", 32'(gnt[gnt_id]), 32'd1);
        if (run_len == 0 && seen) chk("rnd_gap", 32'(zero_len >= GAP + 1), 32'd1);
        run_len++;
        zero_len = 0;
        seen     = 1'b1;
        chk("rnd_hold", 32'(run_len <= MH), 32'd1);
      end else begin
        run_len = 0;
        zero_len++;
      end
      if (hold_timeout) chk("rnd_timeout_len", 32'(prev_run), 32'(MH));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
